// File: rtl/sram_stream_reader_pkg.sv
// Shared widths and helpers for the SRAM stream reader.
// Optional perf counters are enabled by defining SRAM_READER_PERF_EN.
package sram_stream_reader_pkg;

    localparam int SRAM_ADDR_W = 12;
    localparam int NUM_SRAMS   = 8;
    localparam int SRAM_IDX_W  = $clog2(NUM_SRAMS);

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sram_rd_fifo.sv
// Synchronous return-data FIFO for the SRAM stream reader.
// Depth must be a power of two; pushes when full and pops when empty are dropped.
module sram_rd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/sram_stream_reader.sv
// Streams len consecutive SRAM words out as an AXI4-Stream master.
// Define SRAM_READER_PERF_EN to add stall / no-grant cycle counters.
module sram_stream_reader
    import sram_stream_reader_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 64,
    parameter int MAX_ADDR_WIDTH     = SRAM_ADDR_W,
    parameter int LEN_WIDTH          = 16,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [MAX_ADDR_WIDTH-1:0]     base_addr,
    input  logic [LEN_WIDTH-1:0]          len,
    input  logic [SRAM_IDX_W-1:0]         sram_idx,
    output logic                          busy,
    output logic                          done,
    input  logic                          sram_gnt,
    output logic                          sram_out_en,
    output logic [SRAM_IDX_W-1:0]         sram_out_idx,
    output logic [MAX_ADDR_WIDTH-1:0]     sram_out_addr,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] sram_out_data,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast
`ifdef SRAM_READER_PERF_EN
    ,
    output logic [31:0]                   perf_stall_cycles,
    output logic [31:0]                   perf_nogrant_cycles
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                        state;
    logic [LEN_WIDTH-1:0]          len_q;
    logic [LEN_WIDTH-1:0]          issued;
    logic [LEN_WIDTH-1:0]          popped;
    logic [MAX_ADDR_WIDTH-1:0]     base_q;
    logic                          inflight;
    logic [CW-1:0]                 fifo_count;
    logic                          fifo_empty;
    logic                          fifo_full_unused;
    logic [C_AXIS_TDATA_WIDTH-1:0] fifo_head;

    logic                          pop;
    logic                          granted;
    logic                          last_pop;
    logic                          credit_ok;
    logic [LEN_WIDTH-1:0]          issued_n;
    logic [CW-1:0]                 count_n;

    assign pop      = m_axis_tvalid && m_axis_tready;
    assign granted  = sram_out_en && sram_gnt;
    assign issued_n = issued + LEN_WIDTH'(granted);
    assign last_pop = pop && (popped == len_q - LEN_WIDTH'(1));

    // Occupancy after this edge, counting the request being granted now.
    assign count_n   = fifo_count + CW'(inflight) - CW'(pop);
    assign credit_ok = ({1'b0, count_n} + (CW+1)'(granted))
                       < (CW+1)'(FIFO_DEPTH);

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : fifo_head;
    assign m_axis_tlast  = m_axis_tvalid
                           && (popped == len_q - LEN_WIDTH'(1));

    sram_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (C_AXIS_TDATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (pop),
        .din   (sram_out_data),
        .dout  (fifo_head),
        .full  (fifo_full_unused),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            len_q         <= '0;
            base_q        <= '0;
            issued        <= '0;
            popped        <= '0;
            inflight      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            sram_out_en   <= 1'b0;
            sram_out_idx  <= '0;
            sram_out_addr <= '0;
        end else begin
            inflight <= granted;
            if (pop) popped <= popped + LEN_WIDTH'(1);
            unique case (state)
                S_IDLE: begin
                    sram_out_en <= 1'b0;
                    if (start) begin
                        len_q         <= len;
                        base_q        <= base_addr;
                        sram_out_idx  <= sram_idx;
                        sram_out_addr <= base_addr;
                        issued        <= '0;
                        popped        <= '0;
                        if (len != '0) begin
                            state       <= S_RUN;
                            busy        <= 1'b1;
                            sram_out_en <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    issued        <= issued_n;
                    sram_out_addr <= base_q + MAX_ADDR_WIDTH'(issued_n);
                    if (issued_n == len_q) begin
                        state       <= S_DRAIN;
                        sram_out_en <= 1'b0;
                    end else begin
                        sram_out_en <= credit_ok;
                    end
                end
                S_DRAIN: begin
                    if (last_pop) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SRAM_READER_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles   <= '0;
            perf_nogrant_cycles <= '0;
        end else if (state == S_IDLE && start) begin
            perf_stall_cycles   <= '0;
            perf_nogrant_cycles <= '0;
        end else begin
            if ((state == S_RUN || state == S_DRAIN)
                && m_axis_tvalid && !m_axis_tready)
                perf_stall_cycles <= sat_inc32(perf_stall_cycles);
            if (sram_out_en && !sram_gnt)
                perf_nogrant_cycles <= sat_inc32(perf_nogrant_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_sram_stream_reader.sv
// Scoreboard bench for sram_stream_reader: directed transfers, back-pressure,
// grant loss, address wrap, zero length, mid-transfer reset and ignored start.
module tb_sram_stream_reader;

    typedef struct {
        logic [63:0] d;
        logic        l;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] base_addr;
    logic [15:0] len;
    logic [2:0]  sram_idx;
    logic        busy;
    logic        done;
    logic        sram_gnt;
    logic        sram_out_en;
    logic [2:0]  sram_out_idx;
    logic [11:0] sram_out_addr;
    logic [63:0] sram_out_data;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    sram_stream_reader #(
        .C_AXIS_TDATA_WIDTH (64),
        .MAX_ADDR_WIDTH     (12),
        .LEN_WIDTH          (16),
        .FIFO_DEPTH         (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .len           (len),
        .sram_idx      (sram_idx),
        .busy          (busy),
        .done          (done),
        .sram_gnt      (sram_gnt),
        .sram_out_en   (sram_out_en),
        .sram_out_idx  (sram_out_idx),
        .sram_out_addr (sram_out_addr),
        .sram_out_data (sram_out_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    int nchecks = 0;
    int nfail   = 0;
    int cyc     = 0;
    int t0      = 0;
    int req_n   = 0;
    int beats_total = 0;
    int gnt_total   = 0;
    int saw_busy, saw_en, en_cycles, first_en, g0, b0;
    logic drop_en;
    logic [2:0] cur_idx;
    logic hold_v;
    logic [63:0] hold_d;
    logic hold_l;
    beat_t exp_q[$];
    logic [11:0] addr_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] data_of(input logic [2:0] ix,
                                           input logic [11:0] a);
        return {5'h14, ix, 40'h5EED_0000_00, 4'h0, a};
    endfunction

    // SRAM model: one-cycle read latency, junk when not granted.
    always @(posedge clk) begin
        if (sram_out_en && sram_gnt)
            sram_out_data <= data_of(sram_out_idx, sram_out_addr);
        else
            sram_out_data <= 64'hBAD0_BAD0_BAD0_BAD0;
    end

    always @(posedge clk) begin
        if (start && !busy) req_n <= 0;
        else if (sram_out_en) req_n <= req_n + 1;
    end
    assign sram_gnt = !(drop_en && (req_n == 1 || req_n == 2));

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: requests against the address queue, beats against the
    // beat queue, and AXI hold while stalled.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_tvalid", m_axis_tvalid, 1);
                chk("hold_tdata", m_axis_tdata, hold_d);
                chk("hold_tlast", m_axis_tlast, hold_l);
            end
            if (sram_out_en) begin
                if (addr_q.size() == 0) begin
                    chk("unexpected_req", 1, 0);
                end else begin
                    chk("req_addr", sram_out_addr, addr_q[0]);
                    chk("req_idx", sram_out_idx, cur_idx);
                    if (sram_gnt) begin
                        void'(addr_q.pop_front());
                        gnt_total++;
                    end
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                beats_total++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", m_axis_tdata, e.d);
                    chk("beat_last", m_axis_tlast, e.l);
                end
            end
            hold_v = m_axis_tvalid && !m_axis_tready;
            hold_d = m_axis_tdata;
            hold_l = m_axis_tlast;
        end
    end

    task automatic kick(input logic [11:0] b, input logic [15:0] n,
                        input logic [2:0] ix);
        for (int i = 0; i < int'(n); i++) begin
            beat_t e;
            e.d = data_of(ix, b + 12'(i));
            e.l = (i == int'(n) - 1);
            exp_q.push_back(e);
            addr_q.push_back(b + 12'(i));
        end
        cur_idx = ix;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; len = n; sram_idx = ix;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int exp_lat);
        int lat;
        lat = -1; saw_busy = 0; saw_en = 0; en_cycles = 0; first_en = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (busy) saw_busy = 1;
            if (sram_out_en) begin
                en_cycles++;
                if (first_en < 0) first_en = cyc - t0;
            end
            if (done) begin
                lat = cyc - t0;
                break;
            end
        end
        if (lat < 0) begin
            chk({nm, "_done_timeout"}, 0, 1);
        end else begin
            if (exp_lat >= 0) chk({nm, "_done_cycle"}, lat, exp_lat);
            chk({nm, "_beats_left"}, exp_q.size(), 0);
            chk({nm, "_reqs_left"}, addr_q.size(), 0);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_en"}, sram_out_en, 0);
        chk({nm, "_idx"}, sram_out_idx, 0);
        chk({nm, "_addr"}, sram_out_addr, 0);
        chk({nm, "_tvalid"}, m_axis_tvalid, 0);
        chk({nm, "_tlast"}, m_axis_tlast, 0);
        chk({nm, "_tdata"}, m_axis_tdata, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
        sram_idx = '0; m_axis_tready = 1'b1; drop_en = 1'b0;
        cur_idx = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst");
        @(posedge clk); #1;
        rst = 1'b0;

        // Plain 8-word burst
        kick(12'h010, 16'd8, 3'd2);
        wait_done("t1", 11);
        chk("t1_first_en", first_en, 1);
        chk("t1_en_cycles", en_cycles, 8);

        // Back-pressure: only FIFO_DEPTH reads may be issued
        m_axis_tready = 1'b0;
        g0 = gnt_total;
        kick(12'h020, 16'd6, 3'd1);
        fork
            begin
                repeat (14) @(negedge clk);
                chk("t2_reads_stalled", gnt_total - g0, 4);
                chk("t2_en_stalled", sram_out_en, 0);
                chk("t2_tvalid_stalled", m_axis_tvalid, 1);
                repeat (6) @(posedge clk);
                #1 m_axis_tready = 1'b1;
            end
        join_none
        wait_done("t2", -1);
        chk("t2_total_reads", gnt_total - g0, 6);

        // Grant withheld on 2nd and 3rd request cycles
        drop_en = 1'b1;
        kick(12'h005, 16'd3, 3'd4);
        wait_done("t3", 8);
        drop_en = 1'b0;

        // Address wrap
        kick(12'hFFE, 16'd4, 3'd7);
        wait_done("t4", 7);

        // Zero length
        kick(12'h123, 16'd0, 3'd3);
        wait_done("t5", 1);
        chk("t5_busy_seen", saw_busy, 0);
        chk("t5_en_seen", saw_en, 0);

        // Second start during RUN is ignored
        kick(12'h040, 16'd16, 3'd5);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 12'h300; len = 16'd2; sram_idx = 3'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t6", 19);

        // Reset around beat 5 aborts the transfer
        b0 = beats_total;
        kick(12'h080, 16'd16, 3'd3);
        for (int k = 0; k < 100 && beats_total - b0 < 5; k++)
            @(negedge clk);
        chk("t7_beat5_reached", beats_total - b0 >= 5, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("t7_rst");
        exp_q.delete();
        addr_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        saw_busy = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done || m_axis_tvalid || sram_out_en) saw_busy = 1;
        end
        chk("t7_quiet_after_rst", saw_busy, 0);

        // Fresh transfer after the abort
        kick(12'h200, 16'd2, 3'd6);
        wait_done("t8", 5);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", nchecks, nfail);
        $finish;
    end

endmodule
